normalize_seq: RTL

Sequential, parametrised successor to the combinational per-element normaliser. It computes norm_x[i] = (x[i] − mean) / stddev in signed fixed point for an N-element vector, using a single shared bit-serial divider instead of N parallel combinational dividers. It adds valid/ready handshakes, configurable fraction width, optional saturation and divide-by-zero handling. It sits in the layer-norm datapath between the mean/stddev statistics stage and the gamma/beta affine stage.

---
 rtl/normalize_pkg.sv | 29 ++
 rtl/normalize_seq_if.sv | 26 ++
 rtl/normalize_seq_divider.sv | 75 +++++++
 rtl/normalize_seq.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/normalize_pkg.sv
// Shared types and helpers for the sequential layer-norm normaliser.
// Holds the control FSM encoding, quotient width and result clamp.
package normalize_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ITER,
    DONE
  } state_e;

  function automatic int qw(input int dw, input int frac);
    return dw + 1 + frac;
  endfunction

  function automatic logic signed [63:0] sat_clamp(
    input logic signed [63:0] v,
    input int                 dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/normalize_seq_if.sv
// Vector handshake bundle between statistics stage and affine stage.
// master drives the request side, slave is the normaliser.
interface normalize_seq_if #(
  parameter int N  = 4,
  parameter int DW = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N-1:0][DW-1:0]   x;
  logic [DW-1:0]          mean;
  logic [DW-1:0]          stddev;
  logic                   out_valid;
  logic                   out_ready;
  logic [N-1:0][DW-1:0]   norm_x;
  logic                   div_zero;

  modport master (
    output in_valid, x, mean, stddev, out_ready,
    input  in_ready, out_valid, norm_x, div_zero
  );

  modport slave (
    input  in_valid, x, mean, stddev, out_ready,
    output in_ready, out_valid, norm_x, div_zero
  );
endinterface

// File: rtl/normalize_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// done and quotient are valid during the final iteration cycle.
module seq_divider #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dq_q, dq_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic [W:0]    shifted;
  logic [W:0]    trial;
  logic [W-1:0]  step_rem;
  logic [W-1:0]  step_dq;

  always_comb begin
    shifted  = {rem_q, dq_q[W-1]};
    trial    = shifted - {1'b0, dvs_q};
    step_rem = trial[W] ? shifted[W-1:0] : trial[W-1:0];
    step_dq  = {dq_q[W-2:0], ~trial[W]};
  end

  always_comb begin
    rem_d  = rem_q;
    dq_d   = dq_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = '0;
      dq_d   = dividend;
      dvs_d  = divisor;
      cnt_d  = CW'(W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = step_rem;
      dq_d  = step_dq;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      dq_q   <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dq_q   <= dq_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CW'(1));
  assign quotient = step_dq;

endmodule

// File: rtl/normalize_seq.sv
// Layer-norm element normaliser: (x[i] - mean) / stddev per element,
// sharing one bit-serial divider across the whole vector.
module normalize_seq
  import normalize_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter bit SAT  = 1'b1
) (
  input logic            clk,
  input logic            rst,
  normalize_seq_if.slave bus
);
  localparam int QW = qw(DW, FRAC);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [N-1:0][DW-1:0] x_q, x_d;
  logic [N-1:0][DW-1:0] res_q, res_d;
  logic [N-1:0][DW-1:0] norm_q, norm_d;
  logic [DW-1:0]        mean_q, mean_d;
  logic [DW-1:0]        sd_q, sd_d;
  logic                 neg_q, neg_d;
  logic                 dneg_q, dneg_d;
  logic                 dzero_q, dzero_d;
  logic                 divz_q, divz_d;

  logic                 div_start;
  logic                 div_busy;
  logic                 div_done;
  logic [QW-1:0]        div_q;
  logic [QW-1:0]        div_dvd;
  logic [QW-1:0]        div_dvs;

  logic signed [DW:0]   diff;
  logic [DW:0]          diff_mag;
  logic signed [DW:0]   sd_ext;
  logic [DW:0]          sd_mag;
  logic signed [QW:0]   sq;
  logic [DW-1:0]        elem;

  always_comb begin
    diff     = (DW+1)'($signed(x_q[idx_q])) - (DW+1)'($signed(mean_q));
    diff_mag = diff[DW] ? (DW+1)'(-diff) : (DW+1)'(diff);
    sd_ext   = (DW+1)'($signed(sd_q));
    sd_mag   = sd_ext[DW] ? (DW+1)'(-sd_ext) : (DW+1)'(sd_ext);
    div_dvd  = {diff_mag, {FRAC{1'b0}}};
    div_dvs  = QW'(sd_mag);
  end

  assign div_start = (state_q == SETUP) && !div_busy;

  seq_divider #(.W(QW)) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(div_dvd),
    .divisor (div_dvs),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_q)
  );

  // Zero divisor overrides both saturate and wrap modes.
  always_comb begin
    sq   = neg_q ? -$signed({1'b0, div_q}) : $signed({1'b0, div_q});
    elem = '0;
    if (sd_q == '0) begin
      if (dzero_q)     elem = '0;
      else if (dneg_q) elem = {1'b1, {(DW-1){1'b0}}};
      else             elem = {1'b0, {(DW-1){1'b1}}};
    end else if (SAT) begin
      elem = DW'(sat_clamp(64'(sq), DW));
    end else begin
      elem = sq[DW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    mean_d  = mean_q;
    sd_d    = sd_q;
    neg_d   = neg_q;
    dneg_d  = dneg_q;
    dzero_d = dzero_q;
    res_d   = res_q;
    norm_d  = norm_q;
    divz_d  = divz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.x;
          mean_d  = bus.mean;
          sd_d    = bus.stddev;
          idx_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        neg_d   = diff[DW] ^ sd_q[DW-1];
        dneg_d  = diff[DW];
        dzero_d = (diff == '0);
        state_d = ITER;
      end
      ITER: begin
        if (div_done) begin
          res_d[idx_q] = elem;
          if (idx_q == IW'(N - 1)) begin
            norm_d  = res_d;
            divz_d  = (sd_q == '0);
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = SETUP;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      mean_q  <= '0;
      sd_q    <= '0;
      neg_q   <= 1'b0;
      dneg_q  <= 1'b0;
      dzero_q <= 1'b0;
      res_q   <= '0;
      norm_q  <= '0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      mean_q  <= mean_d;
      sd_q    <= sd_d;
      neg_q   <= neg_d;
      dneg_q  <= dneg_d;
      dzero_q <= dzero_d;
      res_q   <= res_d;
      norm_q  <= norm_d;
      divz_q  <= divz_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.norm_x    = norm_q;
  assign bus.div_zero  = divz_q;

endmodule
